paddle_step_controller: RTL and testbench



---
 rtl/pong_pkg.sv | 21 ++
 rtl/paddle_step_controller_if.sv | 28 ++
 rtl/paddle_clamp.sv | 32 +++
 rtl/paddle_step_controller.sv | 120 ++++++++++++
 tb/tb_paddle_step_controller.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// pong_pkg -- shared constants and types for the pong paddle logic.
//   SCREEN_H_DEF / PADDLE_H_DEF : default visible lines and paddle height
//   state_t                     : paddle step FSM state encoding
//   dir_t                       : latched step direction
package pong_pkg;

   localparam int SCREEN_H_DEF = 480;
   localparam int PADDLE_H_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

endpackage

// File: rtl/paddle_step_controller_if.sv
// paddle_step_controller_if -- button inputs, delay-timer handshake and paddle
// position outputs of the paddle step controller.
//   btn_up, btn_down : debounced button levels
//   done             : one-cycle pulse from the delay timer
//   delay            : request to the delay timer, high while waiting
//   paddle_y         : paddle top line
//   moving           : high while a step is pending or executing
// master = controller side, slave = buttons/timer/display side.
interface paddle_step_controller_if;

   logic       btn_up;
   logic       btn_down;
   logic       done;
   logic       delay;
   logic [9:0] paddle_y;
   logic       moving;

   modport master (
      input  btn_up, btn_down, done,
      output delay, paddle_y, moving
   );

   modport slave (
      output btn_up, btn_down, done,
      input  delay, paddle_y, moving
   );

endinterface

// File: rtl/paddle_clamp.sv
// paddle_clamp -- combinational next paddle position for one step.
//   y      : current paddle top line
//   dir    : step direction (DIR_UP toward line 0)
//   step   : lines to move this step
//   next_y : y moved by step, clamped to 0 .. SCREEN_H-PADDLE_H
module paddle_clamp
   import pong_pkg::*;
#(
   parameter int SCREEN_H = SCREEN_H_DEF,
   parameter int PADDLE_H = PADDLE_H_DEF
) (
   input  logic [9:0] y,
   input  dir_t       dir,
   input  logic [9:0] step,
   output logic [9:0] next_y
);

   localparam logic [10:0] Y_MAX = 11'(SCREEN_H - PADDLE_H);

   logic [10:0] sum;

   // The down sum is one bit wider than y so the clamp compare never sees a wrap.
   always_comb begin
      sum = {1'b0, y} + {1'b0, step};
      if (dir == DIR_UP) begin
         next_y = (y < step) ? 10'd0 : y - step;
      end else begin
         next_y = (sum > Y_MAX) ? Y_MAX[9:0] : sum[9:0];
      end
   end

endmodule

// File: rtl/paddle_step_controller.sv
// paddle_step_controller -- moves the paddle one step per delay-timer period
// while a single direction button is held.
//   CLK_100MHz : system clock, rising edge
//   Reset_n    : asynchronous active-low reset
//   bus        : paddle_step_controller_if.master (buttons, done in;
//                delay, paddle_y, moving out)
// Optional build macro PADDLE_ACCEL_EN: after 4 consecutive same-direction
// steps the step size doubles.
//
// state   | meaning
// ST_IDLE | no request; looks for a single valid button
// ST_WAIT | delay requested, waiting for done or an abort
// ST_STEP | one cycle; paddle_y updated on exit
module paddle_step_controller
   import pong_pkg::*;
#(
   parameter int SCREEN_H = SCREEN_H_DEF,
   parameter int PADDLE_H = PADDLE_H_DEF,
   parameter int STEP     = 4,
   parameter int Y_RESET  = 208
) (
   input  logic                      CLK_100MHz,
   input  logic                      Reset_n,
   paddle_step_controller_if.master  bus
);

   localparam logic [9:0] Y_MAX = 10'(SCREEN_H - PADDLE_H);

   state_t     state_q, state_d;
   dir_t       dir_q, dir_d;
   logic       delay_q, moving_q;
   logic [9:0] paddle_y_q, next_y, step_size;
   logic       up_ok, down_ok, abort;

   always_comb begin
      up_ok   = bus.btn_up && !bus.btn_down && (paddle_y_q != 10'd0);
      down_ok = bus.btn_down && !bus.btn_up && (paddle_y_q < Y_MAX);
      abort   = (dir_q == DIR_UP) ? (!bus.btn_up || bus.btn_down)
                                  : (!bus.btn_down || bus.btn_up);
      state_d = state_q;
      dir_d   = dir_q;
      case (state_q)
         ST_IDLE: begin
            if (up_ok) begin
               state_d = ST_WAIT;
               dir_d   = DIR_UP;
            end else if (down_ok) begin
               state_d = ST_WAIT;
               dir_d   = DIR_DOWN;
            end
         end
         // Abort is tested first so it wins over a coincident done.
         ST_WAIT: begin
            if (abort)         state_d = ST_IDLE;
            else if (bus.done) state_d = ST_STEP;
         end
         ST_STEP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= ST_IDLE;
         dir_q      <= DIR_UP;
         delay_q    <= 1'b0;
         moving_q   <= 1'b0;
         paddle_y_q <= 10'(Y_RESET);
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         delay_q  <= (state_d == ST_WAIT);
         moving_q <= (state_d != ST_IDLE);
         if (state_q == ST_STEP) paddle_y_q <= next_y;
      end
   end

`ifdef PADDLE_ACCEL_EN
   logic [2:0] accel_q;

   always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
      if (!Reset_n) begin
         accel_q <= 3'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (state_d != ST_WAIT || dir_d != dir_q) accel_q <= 3'd0;
            end
            ST_WAIT: begin
               if (abort) accel_q <= 3'd0;
            end
            ST_STEP: begin
               if (accel_q != 3'd7) accel_q <= accel_q + 3'd1;
            end
            default: accel_q <= 3'd0;
         endcase
      end
   end

   // The count is sampled before its increment, so steps 1-4 are single size.
   assign step_size = (accel_q >= 3'd4) ? 10'(2 * STEP) : 10'(STEP);
`else
   assign step_size = 10'(STEP);
`endif

   paddle_clamp #(
      .SCREEN_H (SCREEN_H),
      .PADDLE_H (PADDLE_H)
   ) u_clamp (
      .y      (paddle_y_q),
      .dir    (dir_q),
      .step   (step_size),
      .next_y (next_y)
   );

   assign bus.delay    = delay_q;
   assign bus.moving   = moving_q;
   assign bus.paddle_y = paddle_y_q;

endmodule

// File: tb/tb_paddle_step_controller.sv
// tb_paddle_step_controller -- three controller instances (paddle_y after reset
// 208, 2 and 414) checked every cycle against a behavioural model, plus
// literal expectations on the key scenarios. Honours PADDLE_ACCEL_EN.
module tb_paddle_step_controller;

   localparam int Y_MAX = 480 - 64;
`ifdef PADDLE_ACCEL_EN
   localparam bit ACCEL = 1'b1;
`else
   localparam bit ACCEL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]       bu = '0, bd = '0, dn = '0;
   logic [2:0]       dly, mov;
   logic [2:0][9:0]  py;

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      paddle_step_controller_if bus ();
      assign bus.btn_up   = bu[g];
      assign bus.btn_down = bd[g];
      assign bus.done     = dn[g];
      assign dly[g]       = bus.delay;
      assign mov[g]       = bus.moving;
      assign py[g]        = bus.paddle_y;
      paddle_step_controller #(
         .Y_RESET ((g == 0) ? 208 : (g == 1) ? 2 : 414)
      ) u_dut (
         .CLK_100MHz (clk),
         .Reset_n    (rst_n),
         .bus        (bus)
      );
   end

   function automatic int y_after_reset(input int i);
      return (i == 0) ? 208 : (i == 1) ? 2 : 414;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: phase 0 = no request, 1 = waiting for timer, 2 = stepping.
   int m_phase [3];
   int m_dir   [3];   // 0 up, 1 down
   int m_y     [3];
   int m_cnt   [3];

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            m_phase[i] = 0;
            m_dir[i]   = 0;
            m_y[i]     = y_after_reset(i);
            m_cnt[i]   = 0;
         end else begin
            case (m_phase[i])
               0: begin
                  if (bu[i] && !bd[i] && m_y[i] > 0) begin
                     if (m_dir[i] != 0) m_cnt[i] = 0;
                     m_dir[i] = 0;
                     m_phase[i] = 1;
                  end else if (bd[i] && !bu[i] && m_y[i] < Y_MAX) begin
                     if (m_dir[i] != 1) m_cnt[i] = 0;
                     m_dir[i] = 1;
                     m_phase[i] = 1;
                  end else begin
                     m_cnt[i] = 0;
                  end
               end
               1: begin
                  if (!(m_dir[i] == 1 ? (bd[i] && !bu[i]) : (bu[i] && !bd[i]))) begin
                     m_phase[i] = 0;
                     m_cnt[i] = 0;
                  end else if (dn[i]) begin
                     m_phase[i] = 2;
                  end
               end
               default: begin
                  int sz;
                  sz = (ACCEL && m_cnt[i] >= 4) ? 8 : 4;
                  if (m_dir[i] == 1) m_y[i] = (m_y[i] + sz > Y_MAX) ? Y_MAX : m_y[i] + sz;
                  else               m_y[i] = (m_y[i] - sz < 0) ? 0 : m_y[i] - sz;
                  if (m_cnt[i] < 7) m_cnt[i] = m_cnt[i] + 1;
                  m_phase[i] = 0;
               end
            endcase
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk("model_delay",    int'(dly[i]), int'(m_phase[i] == 1));
         chk("model_moving",   int'(mov[i]), int'(m_phase[i] != 0));
         chk("model_paddle_y", int'(py[i]),  m_y[i]);
      end
   end

   // Waits (bounded) until delay is seen high at a negedge.
   task automatic wait_req(input int i);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!dly[i] && n < 30);
      chk("req_seen", int'(dly[i]), 1);
   endtask

   // Answers one delay request with a done pulse 5 cycles later; returns at
   // the negedge of the first idle cycle after the step.
   task automatic do_step(input int i);
      wait_req(i);
      if (dly[i]) begin
         repeat (5) @(posedge clk);
         #1 dn[i] = 1'b1;
         @(posedge clk);
         #1 dn[i] = 1'b0;
         @(negedge clk);
         @(negedge clk);
      end
   endtask

`ifdef PADDLE_ACCEL_EN
   int exp_run [6] = '{212, 216, 220, 224, 232, 240};
`else
   int exp_run [6] = '{212, 216, 220, 224, 228, 232};
`endif

   initial begin
      int y0;
      repeat (3) @(negedge clk);
      chk("reset_y0", int'(py[0]), 208);
      chk("reset_y1", int'(py[1]), 2);
      chk("reset_y2", int'(py[2]), 414);
      chk("reset_delay", int'(dly), 0);
      chk("reset_moving", int'(mov), 0);
      rst_n = 1'b1;

      // Held down button: step run from 208, request re-raised one cycle after idle.
      bd[0] = 1'b1;
      do_step(0);
      chk("run_step1", int'(py[0]), 212);
      chk("run_idle_gap", int'(dly[0]), 0);
      @(negedge clk);
      chk("run_rerequest", int'(dly[0]), 1);
      for (int s = 1; s < 6; s++) begin
         do_step(0);
         chk("run_step", int'(py[0]), exp_run[s]);
      end
      bd[0] = 1'b0;
      @(negedge clk);

      // Up step clamps at 0, then no more requests.
      bu[1] = 1'b1;
      do_step(1);
      chk("up_clamp", int'(py[1]), 0);
      repeat (8) begin
         @(negedge clk);
         chk("up_bound_no_req", int'(dly[1]), 0);
      end
      bu[1] = 1'b0;

      // Down step clamps at 416, then no more requests.
      bd[2] = 1'b1;
      do_step(2);
      chk("down_clamp", int'(py[2]), 416);
      repeat (8) begin
         @(negedge clk);
         chk("down_bound_no_req", int'(dly[2]), 0);
      end
      bd[2] = 1'b0;

      // Release in WAIT, then stray done in IDLE.
      y0 = exp_run[5];
      bd[0] = 1'b1;
      wait_req(0);
      bd[0] = 1'b0;
      @(negedge clk);
      chk("release_delay", int'(dly[0]), 0);
      dn[0] = 1'b1;
      @(negedge clk);
      dn[0] = 1'b0;
      @(negedge clk);
      chk("release_y", int'(py[0]), y0);
      chk("release_idle", int'(mov[0]), 0);

      // Release and done in the same cycle: abort wins.
      bd[0] = 1'b1;
      wait_req(0);
      bd[0] = 1'b0;
      dn[0] = 1'b1;
      @(negedge clk);
      dn[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_wins_y", int'(py[0]), y0);

      // Opposite button aborts.
      bd[0] = 1'b1;
      wait_req(0);
      bu[0] = 1'b1;
      @(negedge clk);
      chk("opposite_abort", int'(dly[0]), 0);

      // Both buttons with done pulsing.
      repeat (10) begin
         dn[0] = ~dn[0];
         @(negedge clk);
         chk("both_no_req", int'(dly[0]), 0);
      end
      dn[0] = 1'b0;
      chk("both_y", int'(py[0]), y0);
      bu[0] = 1'b0;
      bd[0] = 1'b0;
      @(negedge clk);

      // Reset in WAIT drops delay asynchronously and loses the step.
      bd[0] = 1'b1;
      wait_req(0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_delay", int'(dly[0]), 0);
      chk("async_rst_y", int'(py[0]), 208);
      bd[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
